writeback_arbiter: RTL

- Writer side of the dual-write-port register file: collects results from two ALU lanes and one long-latency unit (load/mul-div).
- Drives the register file's writeEnable1/2, writeAddr1/2 and writeData1/2 from a registered output stage.
- Buffers long-latency results in a small FIFO, with starvation protection.
- Exports a pending-write busy mask for issue hazard logic.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 92 +++++++++
 rtl/writeback_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared widths and the write-request record used by the writeback arbiter.
package wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  // One register-file write: enable, destination and result.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with registered count/full/empty. It also exposes a tag
// field (the top TAG_W bits) of every slot together with a per-slot valid
// mask, so the owner can see what is buffered without popping it.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_push,
  input  logic [WIDTH-1:0]                i_push_data,
  input  logic                            i_pop,
  output logic [WIDTH-1:0]                o_head,
  output logic [$clog2(DEPTH):0]          o_count,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [DEPTH-1:0][TAG_W-1:0]     o_tags,
  output logic [DEPTH-1:0]                o_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [CNT_W-1:0]            r_count;
  logic                        r_full;
  logic                        r_empty;
  logic [CNT_W-1:0]            w_count_next;
  logic [PTR_W-1:0]            w_off;
  logic                        w_push;
  logic                        w_pop;

  assign w_push  = i_push && !r_full;
  assign w_pop   = i_pop && !r_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = r_full;
  assign o_empty = r_empty;

  // Storage write.
  // NOTE: the data array is deliberately not reset; slot validity is carried
  // by the pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Next occupancy from the push/pop pair.
  // NOTE: every variable written here gets a default first so no latch forms.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Pointers and registered status flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_W'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  // Slot i is live when its distance from the read pointer is below count.
  always_comb begin
    w_off   = '0;
    o_valid = '0;
    o_tags  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off      = PTR_W'(i) - r_rd_ptr;
      o_valid[i] = ({1'b0, w_off} < r_count);
      o_tags[i]  = r_mem[i][WIDTH-1 -: TAG_W];
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges two ALU lanes and a FIFO-buffered long-latency
// unit onto the two register-file write ports, with starvation protection
// for the FIFO head and a busy mask for the issue hazard logic.
module writeback_arbiter #(
  parameter int DATA_W       = wb_pkg::DATA_W,
  parameter int ADDR_W       = wb_pkg::ADDR_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s0_valid,
  output logic                        s0_ready,
  input  logic [ADDR_W-1:0]           s0_addr,
  input  logic [DATA_W-1:0]           s0_data,
  input  logic                        s1_valid,
  output logic                        s1_ready,
  input  logic [ADDR_W-1:0]           s1_addr,
  input  logic [DATA_W-1:0]           s1_data,
  input  logic                        s2_valid,
  output logic                        s2_ready,
  input  logic [ADDR_W-1:0]           s2_addr,
  input  logic [DATA_W-1:0]           s2_data,
  output logic                        wb_we1,
  output logic                        wb_we2,
  output logic [ADDR_W-1:0]           wb_addr1,
  output logic [ADDR_W-1:0]           wb_addr2,
  output logic [DATA_W-1:0]           wb_data1,
  output logic [DATA_W-1:0]           wb_data2,
  output logic [wb_pkg::NUM_REGS-1:0] busy
);

  import wb_pkg::*;

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic [ENTRY_W-1:0]                 w_head;
  logic [CNT_W-1:0]                   w_count;
  logic                               w_full;
  logic                               w_empty;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0]  w_tags;
  logic [FIFO_DEPTH-1:0]              w_tag_valid;
  logic                               w_head_v;
  logic                               w_push;
  logic                               w_g_head;
  wb_req_t                            w_head_req;
  wb_req_t                            w_s0_req;
  wb_req_t                            w_s1_req;
  wb_req_t                            w_p1;
  wb_req_t                            w_p2;
  wb_req_t                            r_p1;
  wb_req_t                            r_p2;
  logic [WAIT_W-1:0]                  r_wait;
  logic                               r_starve;
  logic [NUM_REGS-1:0]                w_busy;

  // Writes to r0 are dropped at the door; only real destinations are buffered.
  assign w_push = s2_valid && !w_full && (s2_addr != '0);

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .TAG_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data ({s2_addr, s2_data}),
    .i_pop       (w_g_head),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_tags      (w_tags),
    .o_valid     (w_tag_valid)
  );

  // Readies come from registered state only.
  assign s0_ready = 1'b1;
  assign s1_ready = !r_starve;
  assign s2_ready = (w_count < CNT_W'(FIFO_DEPTH));

  assign w_head_v   = !w_empty;
  assign w_head_req = '{valid: w_head_v, addr: w_head[ENTRY_W-1 -: ADDR_W],
                        data: w_head[DATA_W-1:0]};
  assign w_s0_req   = '{valid: s0_valid, addr: s0_addr, data: s0_data};
  assign w_s1_req   = '{valid: s1_valid, addr: s1_addr, data: s1_data};

  // Grant up to two writes; the older candidate always lands on port 1.
  always_comb begin
    w_g_head = 1'b0;
    w_p1     = '0;
    w_p2     = '0;
    if (r_starve) begin
      w_g_head = w_head_v;
      w_p1     = w_head_req;
      if (s0_valid) w_p2 = w_s0_req;
    end else if (w_head_v && !(s0_valid && s1_valid)) begin
      w_g_head = 1'b1;
      w_p1     = w_head_req;
      if (s0_valid)      w_p2 = w_s0_req;
      else if (s1_valid) w_p2 = w_s1_req;
    end else if (s0_valid && s1_valid) begin
      w_p1 = w_s0_req;
      w_p2 = w_s1_req;
      // Same destination in one cycle: the younger lane's result wins.
      if (s0_addr == s1_addr) w_p1.valid = 1'b0;
    end else if (s0_valid) begin
      w_p1 = w_s0_req;
    end else if (s1_valid) begin
      w_p1 = w_s1_req;
    end
    // An r0 write keeps its slot but never enables the register file.
    if (w_p1.addr == '0) w_p1.valid = 1'b0;
    if (w_p2.addr == '0) w_p2.valid = 1'b0;
  end

  // Registered output stage feeding the register-file write ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1 <= '0;
      r_p2 <= '0;
    end else begin
      r_p1 <= w_p1;
      r_p2 <= w_p2;
    end
  end

  assign wb_we1   = r_p1.valid;
  assign wb_addr1 = r_p1.addr;
  assign wb_data1 = r_p1.data;
  assign wb_we2   = r_p2.valid;
  assign wb_addr2 = r_p2.addr;
  assign wb_data2 = r_p2.data;

  // Count how long the FIFO head has been passed over; escalate at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait   <= '0;
      r_starve <= 1'b0;
    end else if (!w_head_v || w_g_head) begin
      r_wait   <= '0;
      r_starve <= 1'b0;
    end else begin
      if (r_wait == WAIT_W'(STARVE_LIMIT - 1)) r_starve <= 1'b1;
      if (r_wait != WAIT_W'(STARVE_LIMIT))     r_wait   <= r_wait + 1'b1;
    end
  end

  // Pending-write mask from buffered entries and the output stage.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_tag_valid[i]) w_busy[w_tags[i]] = 1'b1;
    end
    if (r_p1.valid) w_busy[r_p1.addr] = 1'b1;
    if (r_p2.valid) w_busy[r_p2.addr] = 1'b1;
    w_busy[0] = 1'b0;
  end

  assign busy = w_busy;

endmodule
